// File: rtl/wht_stream_if.sv
// Sample-in / coefficient-out stream bundle for wht_stream.
// The slave modport is the transform engine, the master modport is the surrounding datapath.
`timescale 1ns/1ps
interface wht_stream_if #(
    parameter int DATA_W = 8,
    parameter int LOG2N  = 4
);
    localparam int OUT_W = DATA_W + LOG2N;

    // Handshake: a word moves on a rising edge where valid && ready are both high.
    // in_ready_o and out_valid_o are registered and never look at in_valid_i or out_ready_i
    // combinationally; a producer may not withdraw data while valid is high and not yet taken.
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [OUT_W-1:0]  out_data_o;
    logic [LOG2N-1:0]  out_idx_o;
    logic              out_last_o;
    logic              busy_o;
    logic              frame_done_o;
    logic [1:0]        state_dbg;

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o,
               busy_o, frame_done_o, state_dbg
    );

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_idx_o, out_last_o,
               busy_o, frame_done_o, state_dbg
    );
endinterface

// File: rtl/wht_stream.sv
// Streaming N-point Walsh-Hadamard transform: serial load, in-place butterflies, serial readout.
// Optional macro WHT_NORM_EN adds norm_i, which scales outputs by 1/N (arithmetic shift).
`timescale 1ns/1ps
module wht_stream #(
    parameter int DATA_W = 8,
    parameter int LOG2N  = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
`ifdef WHT_NORM_EN
    input  logic       norm_i,
`endif
    wht_stream_if.slave bus
);
    localparam int N     = 1 << LOG2N;
    localparam int OUT_W = DATA_W + LOG2N;
    localparam int STG_W = (LOG2N > 1) ? $clog2(LOG2N) : 1;

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_OUTPUT  = 2'd2;

    logic [1:0]              state;
    logic [LOG2N-1:0]        load_idx;
    logic [STG_W-1:0]        stage;
    logic [LOG2N-1:0]        out_idx;
    logic [LOG2N-1:0]        nxt_idx;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_last;
    logic                    in_ready;
    logic                    frame_done;
    logic                    norm_q;
    logic signed [OUT_W-1:0] ext;

    logic signed [OUT_W-1:0] b    [N];
    logic signed [OUT_W-1:0] bfly [LOG2N][N];

    function automatic logic signed [OUT_W-1:0] scale(input logic signed [OUT_W-1:0] v,
                                                      input logic nm);
        return nm ? (v >>> LOG2N) : v;
    endfunction

    assign ext     = {{LOG2N{bus.in_data_i[DATA_W-1]}}, bus.in_data_i};
    assign nxt_idx = out_idx + 1'b1;

    // Every stage's butterfly result is precomputed; the FSM picks the active stage.
    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        localparam int H = N >> (s + 1);
        for (genvar i = 0; i < N; i++) begin : g_lane
            if ((i & H) == 0) begin : g_sum
                assign bfly[s][i] = b[i] + b[i+H];
            end else begin : g_diff
                assign bfly[s][i] = b[i-H] - b[i];
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= ST_LOAD;
            load_idx   <= '0;
            stage      <= '0;
            out_idx    <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            in_ready   <= 1'b1;
            frame_done <= 1'b0;
            norm_q     <= 1'b0;
            for (int i = 0; i < N; i++) b[i] <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (bus.in_valid_i && in_ready) begin
                        b[load_idx] <= ext;
`ifdef WHT_NORM_EN
                        if (load_idx == '0) norm_q <= norm_i;
`endif
                        if (load_idx == '1) begin
                            state    <= ST_COMPUTE;
                            in_ready <= 1'b0;
                            load_idx <= '0;
                            stage    <= '0;
                        end else begin
                            load_idx <= load_idx + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    for (int i = 0; i < N; i++) b[i] <= bfly[stage][i];
                    if (stage == STG_W'(LOG2N - 1)) begin
                        // Coefficient 0 comes straight from the final stage so it is valid with no bubble.
                        state     <= ST_OUTPUT;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                        out_last  <= 1'b0;
                        out_data  <= scale(bfly[stage][0], norm_q);
                    end else begin
                        stage <= stage + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (bus.out_ready_i && out_valid) begin
                        if (out_last) begin
                            state      <= ST_LOAD;
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            out_idx    <= '0;
                            out_data   <= '0;
                            in_ready   <= 1'b1;
                            frame_done <= 1'b1;
                        end else begin
                            out_idx  <= nxt_idx;
                            out_data <= scale(b[nxt_idx], norm_q);
                            out_last <= (nxt_idx == '1);
                        end
                    end
                end
                default: begin
                    state     <= ST_LOAD;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready_o   = in_ready;
    assign bus.out_valid_o  = out_valid;
    assign bus.out_data_o   = out_data;
    assign bus.out_idx_o    = out_idx;
    assign bus.out_last_o   = out_last;
    assign bus.busy_o       = (state != ST_LOAD);
    assign bus.frame_done_o = frame_done;
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_wht_stream.sv
// Bench for wht_stream: a 16-point instance (table, backpressure, reset, random) and an 8-point
// 4-bit instance (random), both compared against a direct sum-of-signs reference model.
`timescale 1ns/1ps
module tb_wht_stream;
  localparam int AW = 8;
  localparam int AL = 4;
  localparam int AN = 16;
  localparam int BW = 4;
  localparam int BL = 3;
  localparam int BN = 8;

  typedef int arr_t [64];
  typedef struct {
    string nm;
    int    x [16];
    int    y [16];
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic norm_a = 1'b0;
  logic norm_b = 1'b0;
  int   n_vec = 0;
  int   n_mis = 0;
  vec_t tbl [5];

  wht_stream_if #(.DATA_W(AW), .LOG2N(AL)) bus_a ();
  wht_stream_if #(.DATA_W(BW), .LOG2N(BL)) bus_b ();

  wht_stream #(.DATA_W(AW), .LOG2N(AL)) dut_a (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
`ifdef WHT_NORM_EN
    .norm_i   (norm_a),
`endif
    .bus      (bus_a)
  );

  wht_stream #(.DATA_W(BW), .LOG2N(BL)) dut_b (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
`ifdef WHT_NORM_EN
    .norm_i   (norm_b),
`endif
    .bus      (bus_b)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // reference model: y_k = sum_j (-1)^popcount(j&k) x_j, optionally floor-divided by N
  function automatic arr_t wht_ref(input arr_t x, input int lg, input bit nm);
    arr_t y;
    int   n = 1 << lg;
    int   s;
    for (int k = 0; k < 64; k++) y[k] = 0;
    for (int k = 0; k < n; k++) begin
      s = 0;
      for (int j = 0; j < n; j++) s += ($countones(j & k) % 2 == 1) ? -x[j] : x[j];
      y[k] = nm ? (s >>> lg) : s;
    end
    return y;
  endfunction

  // scoreboard compare
  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // driver tasks, instance A
  task automatic push_a(input int v, input bit nm);
    int t = 0;
    bus_a.in_valid_i = 1'b1;
    bus_a.in_data_i  = AW'(v);
    norm_a           = nm;
    while (!bus_a.in_ready_o && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("push_a_ready_timeout", t, 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_a(input arr_t x, input bit nm);
    // norm is only meaningful with sample 0; the opposite value afterwards checks it is held
    for (int i = 0; i < AN; i++) push_a(x[i], (i == 0) ? nm : !nm);
    bus_a.in_valid_i = 1'b0;
  endtask

  task automatic collect_a(input int mode, input bit junk, output arr_t y, output int lat);
    int       pat [6] = '{1, 0, 0, 1, 0, 1};
    int       t = 0;
    int       got = 0;
    int       pi = 0;
    bit       rdy;
    bit       stall = 1'b0;
    logic [AW+AL-1:0] hd = '0;
    logic [AL-1:0]    hi = '0;
    logic             hl = 1'b0;
    for (int k = 0; k < 64; k++) y[k] = 0;
    bus_a.out_ready_i = 1'b0;
    while (!bus_a.out_valid_o && t < 100) begin @(negedge clk); t++; end
    lat = t;
    if (t >= 100) chk("out_valid_timeout", t, 0);
    t = 0;
    while (got < AN && t < 2000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[pi % 6] == 1;
        default: rdy = $urandom_range(0, 1) == 1;
      endcase
      pi++;
      bus_a.out_ready_i = rdy;
      if (junk) begin
        bus_a.in_valid_i = 1'b1;
        bus_a.in_data_i  = AW'($urandom_range(0, 255));
        chk("in_ready_low_in_output", bus_a.in_ready_o, 0);
      end
      chk("out_valid_no_bubble", bus_a.out_valid_o, 1);
      if (stall) begin
        chk("hold_data", bus_a.out_data_o, hd);
        chk("hold_idx", bus_a.out_idx_o, hi);
        chk("hold_last", bus_a.out_last_o, hl);
      end
      if (bus_a.out_valid_o && rdy) begin
        chk("out_idx", bus_a.out_idx_o, got);
        chk("out_last", bus_a.out_last_o, got == AN - 1);
        y[got] = int'($signed(bus_a.out_data_o));
        got++;
        stall = 1'b0;
      end else begin
        stall = bus_a.out_valid_o;
        hd = bus_a.out_data_o;
        hi = bus_a.out_idx_o;
        hl = bus_a.out_last_o;
      end
      @(negedge clk);
      t++;
    end
    bus_a.in_valid_i = 1'b0;
    if (got < AN) chk("collect_a_timeout", got, AN);
    chk("frame_done_pulse", bus_a.frame_done_o, 1);
    chk("in_ready_after_frame", bus_a.in_ready_o, 1);
    chk("out_valid_after_frame", bus_a.out_valid_o, 0);
    chk("busy_after_frame", bus_a.busy_o, 0);
    @(negedge clk);
    chk("frame_done_one_cycle", bus_a.frame_done_o, 0);
  endtask

  // driver task, instance B: load, then drain with random backpressure
  task automatic frame_b(input arr_t x, input bit nm, output arr_t y);
    int t;
    int got = 0;
    bit rdy;
    for (int k = 0; k < 64; k++) y[k] = 0;
    for (int i = 0; i < BN; i++) begin
      t = 0;
      bus_b.in_valid_i = 1'b1;
      bus_b.in_data_i  = BW'(x[i]);
      norm_b           = (i == 0) ? nm : !nm;
      while (!bus_b.in_ready_o && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) chk("push_b_ready_timeout", t, 0);
      @(posedge clk);
      @(negedge clk);
    end
    bus_b.in_valid_i = 1'b0;
    t = 0;
    while (got < BN && t < 2000) begin
      rdy = $urandom_range(0, 1) == 1;
      bus_b.out_ready_i = rdy;
      if (bus_b.out_valid_o && rdy) begin
        chk("b_out_idx", bus_b.out_idx_o, got);
        chk("b_out_last", bus_b.out_last_o, got == BN - 1);
        y[got] = int'($signed(bus_b.out_data_o));
        got++;
      end
      @(negedge clk);
      t++;
    end
    if (got < BN) chk("collect_b_timeout", got, BN);
    chk("b_frame_done", bus_b.frame_done_o, 1);
    bus_b.out_ready_i = 1'b0;
  endtask

  initial begin
    arr_t x, y, e, z;
    int   lat;
    bit   nm;

    // vector table: hand-derived transforms of simple inputs
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 16; k++) begin tbl[i].x[k] = 0; tbl[i].y[k] = 0; end
    tbl[0].nm = "impulse";
    tbl[0].x[0] = 1;
    for (int k = 0; k < 16; k++) tbl[0].y[k] = 1;
    tbl[1].nm = "dc_fullscale";
    for (int k = 0; k < 16; k++) tbl[1].x[k] = -128;
    tbl[1].y[0] = -2048;
    tbl[2].nm = "alternating";
    for (int k = 0; k < 16; k++) tbl[2].x[k] = (k % 2 == 1) ? 5 : -3;
    tbl[2].y[0] = 16;
    tbl[2].y[1] = -64;
    tbl[3].nm = "ramp";
    for (int k = 0; k < 16; k++) tbl[3].x[k] = k;
    tbl[3].y[0] = 120; tbl[3].y[1] = -8; tbl[3].y[2] = -16; tbl[3].y[4] = -32; tbl[3].y[8] = -64;
    tbl[4].nm = "x1_only";
    tbl[4].x[1] = 1;
    for (int k = 0; k < 16; k++) tbl[4].y[k] = (k % 2 == 0) ? 1 : -1;

    bus_a.in_valid_i = 1'b0; bus_a.in_data_i = '0; bus_a.out_ready_i = 1'b0;
    bus_b.in_valid_i = 1'b0; bus_b.in_data_i = '0; bus_b.out_ready_i = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus_a.in_ready_o, 1);
    chk("rst_out_valid", bus_a.out_valid_o, 0);
    chk("rst_out_last", bus_a.out_last_o, 0);
    chk("rst_out_idx", bus_a.out_idx_o, 0);
    chk("rst_out_data", bus_a.out_data_o, 0);
    chk("rst_busy", bus_a.busy_o, 0);
    chk("rst_frame_done", bus_a.frame_done_o, 0);
    chk("rst_state", bus_a.state_dbg, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus_a.in_ready_o, 1);

    // table-driven frames, consumer always ready
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 64; k++) x[k] = (k < 16) ? tbl[i].x[k] : 0;
      send_a(x, 1'b0);
      collect_a(0, 1'b0, y, lat);
      if (i == 0) chk("first_out_latency", lat, AL);
      for (int k = 0; k < AN; k++) chk(tbl[i].nm, y[k], tbl[i].y[k]);
    end

    // backpressure pattern with junk input offered throughout output
    for (int k = 0; k < 64; k++) x[k] = (k < 16) ? tbl[3].x[k] : 0;
    send_a(x, 1'b0);
    collect_a(1, 1'b1, y, lat);
    for (int k = 0; k < AN; k++) chk("ramp_backpressure", y[k], tbl[3].y[k]);
    for (int k = 0; k < 64; k++) x[k] = (k == 0) ? 1 : 0;
    send_a(x, 1'b0);
    collect_a(0, 1'b0, y, lat);
    for (int k = 0; k < AN; k++) chk("impulse_after_junk", y[k], 1);

    // asynchronous reset during compute stage 2
    for (int k = 0; k < 64; k++) x[k] = (k < 16) ? tbl[3].x[k] : 0;
    send_a(x, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy", bus_a.busy_o, 1);
    chk("mid_state_compute", bus_a.state_dbg, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", bus_a.busy_o, 0);
    chk("arst_in_ready", bus_a.in_ready_o, 1);
    chk("arst_out_valid", bus_a.out_valid_o, 0);
    chk("arst_out_data", bus_a.out_data_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_arst_no_output", bus_a.out_valid_o, 0);
    end
    chk("post_arst_in_ready", bus_a.in_ready_o, 1);
    for (int k = 0; k < 64; k++) x[k] = (k == 0) ? 1 : 0;
    send_a(x, 1'b0);
    collect_a(0, 1'b0, y, lat);
    for (int k = 0; k < AN; k++) chk("impulse_after_reset", y[k], 1);

    // random frames against the reference model
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < 64; k++) x[k] = (k < AN) ? int'($urandom_range(0, 255)) - 128 : 0;
`ifdef WHT_NORM_EN
      nm = $urandom_range(0, 1) == 1;
`else
      nm = 1'b0;
`endif
      send_a(x, nm);
      collect_a(2, f % 2 == 1, y, lat);
      e = wht_ref(x, AL, nm);
      for (int k = 0; k < AN; k++) chk("random_a", y[k], e[k]);
    end

`ifdef WHT_NORM_EN
    // forward, then normalised forward, recovers the input exactly
    for (int k = 0; k < 64; k++) x[k] = (k < AN) ? int'($urandom_range(0, 14)) - 7 : 0;
    send_a(x, 1'b0);
    collect_a(0, 1'b0, y, lat);
    send_a(y, 1'b1);
    collect_a(2, 1'b0, z, lat);
    for (int k = 0; k < AN; k++) chk("norm_roundtrip", z[k], x[k]);
`endif

    // small instance: 8-point, 4-bit samples
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 64; k++) x[k] = (k < BN) ? int'($urandom_range(0, 15)) - 8 : 0;
      if (f == 0) for (int k = 0; k < BN; k++) x[k] = -8;
`ifdef WHT_NORM_EN
      nm = $urandom_range(0, 1) == 1;
`else
      nm = 1'b0;
`endif
      frame_b(x, nm, y);
      e = wht_ref(x, BL, nm);
      for (int k = 0; k < BN; k++) chk("random_b", y[k], e[k]);
    end

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
